// File: rtl/csr_trap_sequencer.sv
// Sequences Zicsr writes, ecall trap entry and mret return onto the single CSR write/read port pair.
// Latency: write 1 cycle + done; ecall redirect at T+5; mret redirect at T+3; reserved kind done at T+1.
// Backpressure: req_ready only in IDLE; one request in flight, inputs ignored while busy, no queue.
module csr_trap_sequencer #(
  parameter int          XLEN        = 32,
  parameter int unsigned ECALL_CAUSE = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_kind,
  input  logic [XLEN-1:0] req_pc,
  input  logic [11:0]     req_csr_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            csr_wen,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic [11:0]     csr_raddr,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            redir_valid,
  output logic [XLEN-1:0] redir_pc,
  output logic            done,
  output logic            busy
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [1:0] KIND_WRITE = 2'd0;
  localparam logic [1:0] KIND_ECALL = 2'd1;
  localparam logic [1:0] KIND_MRET  = 2'd2;

  // mstatus field positions
  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_LO   = 11;
  localparam int MPP_HI   = 12;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_CSR,
    S_W_EPC,
    S_W_CAUSE,
    S_W_STAT_E,
    S_RD_TVEC,
    S_RD_EPC,
    S_W_STAT_R,
    S_REDIR,
    S_FIN
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   target;       // redirect target captured from mtvec/mepc
  logic [XLEN-1:0]   redir_pc_q;   // only updated when a redirect is issued
  logic              wen_q;
  logic [11:0]       waddr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [11:0]       raddr_q;
  logic              redir_q;
  logic              done_q;
  logic              busy_q;
  logic              ready_q;

  logic [XLEN-1:0]   stat_enter;   // mstatus image for trap entry
  logic [XLEN-1:0]   stat_return;  // mstatus image for mret

  // FSM: each transition loads the output registers for the state being entered,
  // so every control output is a flop and the CSR port timing is fixed per state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      target     <= '0;
      redir_pc_q <= '0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      raddr_q    <= '0;
      redir_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;   // gated by rst at the port, so IDLE is ready once rst drops
    end else begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      raddr_q <= '0;
      redir_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
      ready_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            case (req_kind)
              KIND_WRITE: begin
                state   <= S_W_CSR;
                wen_q   <= 1'b1;
                waddr_q <= req_csr_addr;
                wdata_q <= req_wdata;
              end
              KIND_ECALL: begin
                // mepc goes first so the trapping PC is safe before mstatus changes
                state   <= S_W_EPC;
                wen_q   <= 1'b1;
                waddr_q <= CSR_MEPC;
                wdata_q <= req_pc;
              end
              KIND_MRET: begin
                state   <= S_RD_EPC;
                raddr_q <= CSR_MEPC;
              end
              default: begin
                // reserved kind: acknowledge without touching the CSR file
                state  <= S_FIN;
                done_q <= 1'b1;
              end
            endcase
          end else begin
            state   <= S_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        S_W_CSR: begin
          state  <= S_FIN;
          done_q <= 1'b1;
        end
        S_W_EPC: begin
          state   <= S_W_CAUSE;
          wen_q   <= 1'b1;
          waddr_q <= CSR_MCAUSE;
          wdata_q <= XLEN'(ECALL_CAUSE);
        end
        S_W_CAUSE: begin
          // mstatus write data is formed combinationally from the live read
          state   <= S_W_STAT_E;
          wen_q   <= 1'b1;
          waddr_q <= CSR_MSTATUS;
          raddr_q <= CSR_MSTATUS;
        end
        S_W_STAT_E: begin
          state   <= S_RD_TVEC;
          raddr_q <= CSR_MTVEC;
        end
        S_RD_TVEC: begin
          // direct mode only: vectored-mode bits are dropped
          state      <= S_REDIR;
          target     <= {csr_rdata[XLEN-1:2], 2'b00};
          redir_pc_q <= {csr_rdata[XLEN-1:2], 2'b00};
          redir_q    <= 1'b1;
          done_q     <= 1'b1;
        end
        S_RD_EPC: begin
          state   <= S_W_STAT_R;
          target  <= csr_rdata;
          wen_q   <= 1'b1;
          waddr_q <= CSR_MSTATUS;
          raddr_q <= CSR_MSTATUS;
        end
        S_W_STAT_R: begin
          state      <= S_REDIR;
          redir_pc_q <= target;
          redir_q    <= 1'b1;
          done_q     <= 1'b1;
        end
        S_REDIR, S_FIN: begin
          state   <= S_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= S_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // mstatus images: trap entry stacks MIE into MPIE, mret restores it; MPP stays M-mode
  always_comb begin
    stat_enter              = csr_rdata;
    stat_enter[MPIE_BIT]    = csr_rdata[MIE_BIT];
    stat_enter[MIE_BIT]     = 1'b0;
    stat_enter[MPP_HI:MPP_LO] = 2'b11;

    stat_return               = csr_rdata;
    stat_return[MIE_BIT]      = csr_rdata[MPIE_BIT];
    stat_return[MPIE_BIT]     = 1'b1;
    stat_return[MPP_HI:MPP_LO] = 2'b11;
  end

  // write data: read-modify-write states use the value read in the same cycle
  always_comb begin
    csr_wdata = wdata_q;
    if (rst) begin
      csr_wdata = '0;
    end else if (state == S_W_STAT_E) begin
      csr_wdata = stat_enter;
    end else if (state == S_W_STAT_R) begin
      csr_wdata = stat_return;
    end
  end

  // every output is forced low while reset is held, including mid-sequence
  assign req_ready   = ready_q & ~rst;
  assign busy        = busy_q & ~rst;
  assign csr_wen     = wen_q & ~rst;
  assign csr_waddr   = rst ? 12'h000 : waddr_q;
  assign csr_raddr   = rst ? 12'h000 : raddr_q;
  assign redir_valid = redir_q & ~rst;
  assign redir_pc    = rst ? '0 : redir_pc_q;
  assign done        = done_q & ~rst;

endmodule
